icache_sa: RTL and testbench
============================

ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 Parameter ADDR_W, default 32, meaning byte-address width on CPU and memory ports.
REQ-002 Parameter LINE_BYTES, default 16, meaning cache line size in bytes (power of 2, >= MEM_DW/8).
REQ-003 Parameter SETS, default 32, meaning number of sets (power of 2).
REQ-004 Parameter WAYS, default 2, meaning associativity, legal values 1 or 2.
REQ-005 Parameter MEM_DW, default 64, meaning memory data width; BEATS = LINE_BYTES*8/MEM_DW.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 preif_raddr_i  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-009 preif_raddr_valid_i  input  1  fetch request; held with stable address until if_rdata_valid_o.
REQ-010 fence_i  input  1  single-cycle pulse, invalidate entire cache.
REQ-011 if_rdata_o  output  64  {32'b0, instruction}; all zero when if_rdata_valid_o low.
REQ-012 if_rdata_valid_o  output  1  instruction valid, one cycle per accepted hit.
REQ-013 ram_raddr_icache_o  output  ADDR_W  refill beat address, MEM_DW/8-aligned.
REQ-014 ram_raddr_valid_icache_o  output  1  refill beat request.
REQ-015 ram_rmask_icache_o  output  MEM_DW/8  read byte mask, all ones while requesting.
REQ-016 ram_rdata_ready_icache_i  input  1  memory returns current beat this cycle.
REQ-017 ram_rdata_icache_i  input  MEM_DW  beat data.

Function
REQ-018 Address split SHALL be offset = log2(LINE_BYTES) bits, index = log2(SETS) bits, tag = remaining upper bits.
REQ-019 Each way SHALL hold per set a valid bit, tag and line; each set SHALL hold one LRU bit (unused when WAYS=1).
REQ-020 States SHALL be IDLE, MISS, REFILL; only IDLE accepts requests or fence_i.
REQ-021 IDLE with request and hit (valid and tag match in any way): if_rdata_valid_o=1 next cycle with the 32-bit word at address bits [offset-1:2], state stays IDLE.
REQ-022 On hit to way w, LRU of that set SHALL become (not w).
REQ-023 IDLE with request and miss: latch line base address and victim way, go MISS next cycle, if_rdata_valid_o=0.
REQ-024 Victim SHALL be the lowest-numbered invalid way, else the way named by LRU.
REQ-025 MISS: ram_raddr_valid_icache_o=1, address = line base + k*MEM_DW/8 for beat k=0..BEATS-1; beat k stored and k incremented on each cycle ram_rdata_ready_icache_i=1.
REQ-026 On last beat accepted: ram_raddr_valid_icache_o=0 next cycle, state REFILL.
REQ-027 REFILL (one cycle): write line, tag, valid=1 into victim way, LRU = (not victim); next state IDLE, where held request re-looks up and hits.
REQ-028 Miss latency: from request cycle to if_rdata_valid_o = 1 + (cycles spent in MISS) + 2.
REQ-029 fence_i in IDLE: all valid bits and LRU bits cleared at next edge; fence_i has priority over a simultaneous request, which gets no response that cycle and re-looks up next cycle (miss).
REQ-030 fence_i during MISS or REFILL SHALL be latched and applied in the first IDLE cycle, with identical priority to REQ-029.
REQ-031 ram_rdata_ready_icache_i outside MISS SHALL be ignored.
REQ-032 preif_raddr_valid_i low in IDLE: no state change, if_rdata_valid_o=0 next cycle.

Reset
REQ-033 rst asserted at any time, including mid-MISS, SHALL immediately force: state IDLE, all valid and LRU bits 0, beat counter 0, pending flush 0, if_rdata_valid_o=0, if_rdata_o=0, ram_raddr_valid_icache_o=0, ram_raddr_icache_o=0, ram_rmask_icache_o=0.
REQ-034 Line data and tag storage need no reset.

Verification (defaults: 16 B lines, 32 sets, 2 ways, 2 beats)
REQ-035 Cold miss: fetch 0x8000_0004, memory returns 0x0000_0013_1111_1111 at 0x8000_0000, ready immediately -> beats at 0x8000_0000 and 0x8000_0008, if_rdata_o=0x13 at cycle 5.
REQ-036 Hit after fill: fetch 0x8000_0000 -> if_rdata_o=0x1111_1111 next cycle, no memory request.
REQ-037 Conflict/LRU: fill 0x8000_0000, 0x8000_0200 (same set 0), hit 0x8000_0000, fetch 0x8000_0400 -> evicts 0x8000_0200's way; refetch 0x8000_0000 hits, 0x8000_0200 misses.
REQ-038 Flush: after fills, pulse fence_i together with request to 0x8000_0000 -> no response that cycle, next lookup misses and refills.
REQ-039 Reset mid-refill: assert rst after beat 0 accepted -> ram_raddr_valid_icache_o drops same cycle; after release, 0x8000_0000 misses.
REQ-040 Memory stall: ready low 10 cycles per beat -> addresses held stable, single if_rdata_valid_o pulse at cycle 25.

Source files
------------

// File: rtl/icache_sa.sv
// Set-associative (1 or 2 way) instruction cache with LRU replacement and
// multi-beat line refill from a wide memory port.
module icache_sa #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int MEM_DW     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     preif_raddr_i,
  input  logic                  preif_raddr_valid_i,
  input  logic                  fence_i,
  output logic [63:0]           if_rdata_o,
  output logic                  if_rdata_valid_o,
  output logic [ADDR_W-1:0]     ram_raddr_icache_o,
  output logic                  ram_raddr_valid_icache_o,
  output logic [MEM_DW/8-1:0]   ram_rmask_icache_o,
  input  logic                  ram_rdata_ready_icache_i,
  input  logic [MEM_DW-1:0]     ram_rdata_icache_i
);

  localparam int BEATS  = LINE_BYTES * 8 / MEM_DW;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BB_W   = $clog2(MEM_DW / 8);
  localparam int DW_SH  = $clog2(MEM_DW);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WSEL_W = OFF_W - 2;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]   valid_mem [WAYS];
  logic [SETS-1:0]   lru_mem;
  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];

  logic [CNT_W-1:0]  beat_cnt;
  logic              flush_pend;
  logic [TAG_W-1:0]  line_tag;
  logic [IDX_W-1:0]  line_idx;
  logic              victim_q;
  logic [LINE_W-1:0] fill_buf;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              unused_addr_lsb;

  logic [WAYS-1:0]   hit_vec_p0;
  logic              hit_p0;
  logic              hit_w_p0;
  logic              victim_p0;
  logic [LINE_W-1:0] line_p0;
  logic [31:0]       word_p0;

  logic              flush_now;
  logic              lookup_p0;
  logic              take_hit;
  logic              take_miss;
  logic              beat_done;
  logic              last_beat;
  logic [OFF_W-1:0]  beat_off;

  logic              vld_p1;
  logic [63:0]       rdata_p1;

  assign req_tag         = preif_raddr_i[ADDR_W-1 -: TAG_W];
  assign req_idx         = preif_raddr_i[OFF_W +: IDX_W];
  assign req_wsel        = preif_raddr_i[2 +: WSEL_W];
  assign unused_addr_lsb = &{1'b0, preif_raddr_i[1:0]};

  // Lookup stage (p0): tag compare, word select and victim choice
  always_comb begin
    hit_vec_p0 = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_p0[w] = valid_mem[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
    end
    hit_p0   = |hit_vec_p0;
    hit_w_p0 = (WAYS == 2) ? hit_vec_p0[WAYS-1] : 1'b0;
    line_p0  = data_mem[hit_w_p0][req_idx];
    word_p0  = line_p0[{req_wsel, 5'b0} +: 32];
    if (!valid_mem[0][req_idx]) begin
      victim_p0 = 1'b0;
    end else if ((WAYS == 2) && !valid_mem[WAYS-1][req_idx]) begin
      victim_p0 = 1'b1;
    end else begin
      victim_p0 = (WAYS == 2) ? lru_mem[req_idx] : 1'b0;
    end
  end

  // A pending or fresh fence wins over a lookup in the same IDLE cycle.
  assign flush_now = fence_i | flush_pend;
  assign lookup_p0 = (state_q == IDLE) && preif_raddr_valid_i && !flush_now;
  assign take_hit  = lookup_p0 && hit_p0;
  assign take_miss = lookup_p0 && !hit_p0;
  assign beat_done = (state_q == MISS) && ram_rdata_ready_icache_i;
  assign last_beat = beat_done && (beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_miss) state_d = MISS;
      MISS:    if (last_beat) state_d = REFILL;
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      lru_mem    <= '0;
      for (int w = 0; w < WAYS; w++) valid_mem[w] <= '0;
      vld_p1     <= 1'b0;
      rdata_p1   <= '0;
    end else begin
      state_q <= state_d;
      if (take_miss) begin
        beat_cnt <= '0;
      end else if (beat_done) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (state_q == IDLE) begin
        flush_pend <= 1'b0;
      end else if (fence_i) begin
        flush_pend <= 1'b1;
      end
      if ((state_q == IDLE) && flush_now) begin
        lru_mem <= '0;
        for (int w = 0; w < WAYS; w++) valid_mem[w] <= '0;
      end else if (take_hit) begin
        lru_mem[req_idx] <= ~hit_w_p0;
      end else if (state_q == REFILL) begin
        valid_mem[victim_q][line_idx] <= 1'b1;
        lru_mem[line_idx]             <= ~victim_q;
      end
      // Response register (p1)
      vld_p1   <= take_hit;
      rdata_p1 <= take_hit ? {32'b0, word_p0} : 64'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (take_miss) begin
      line_tag <= req_tag;
      line_idx <= req_idx;
      victim_q <= victim_p0;
    end
    if (beat_done) begin
      fill_buf[{beat_cnt, {DW_SH{1'b0}}} +: MEM_DW] <= ram_rdata_icache_i;
    end
    if (state_q == REFILL) begin
      tag_mem[victim_q][line_idx]  <= line_tag;
      data_mem[victim_q][line_idx] <= fill_buf;
    end
  end

  assign beat_off = OFF_W'(beat_cnt) << BB_W;

  assign if_rdata_o               = rdata_p1;
  assign if_rdata_valid_o         = vld_p1;
  assign ram_raddr_valid_icache_o = (state_q == MISS);
  assign ram_raddr_icache_o       = (state_q == MISS) ? {line_tag, line_idx, beat_off} : '0;
  assign ram_rmask_icache_o       = (state_q == MISS) ? '1 : '0;

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: cold miss, hits, LRU conflict, fences,
// reset during refill, memory stalls and back-to-back hits.
module tb_icache_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        req;
  logic        fence;
  logic [63:0] if_rdata;
  logic        if_vld;
  logic [31:0] ram_addr;
  logic        ram_vld;
  logic [7:0]  ram_mask;
  logic        ram_ready;
  logic [63:0] ram_data;

  int vectors = 0;
  int miscompares = 0;

  int stall = 0;
  bit junk = 0;
  int wait_cnt = 0;
  int req_cyc = 0;
  int pulse_cnt = 0;
  bit unstable = 0;
  bit mask_bad = 0;
  logic [31:0] hold_addr;
  logic [31:0] beat_q[$];

  icache_sa dut (
    .clk                      (clk),
    .rst                      (rst),
    .preif_raddr_i            (addr),
    .preif_raddr_valid_i      (req),
    .fence_i                  (fence),
    .if_rdata_o               (if_rdata),
    .if_rdata_valid_o         (if_vld),
    .ram_raddr_icache_o       (ram_addr),
    .ram_raddr_valid_icache_o (ram_vld),
    .ram_rmask_icache_o       (ram_mask),
    .ram_rdata_ready_icache_i (ram_ready),
    .ram_rdata_icache_i       (ram_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat_of(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_1111_1111;
    return {a + 32'd4, a};
  endfunction

  // Memory responder: answers each beat after `stall` idle cycles.
  always @(posedge clk) begin
    #1;
    if (if_vld) pulse_cnt++;
    if (ram_vld && !rst) begin
      req_cyc++;
      if (ram_mask !== 8'hFF) mask_bad = 1;
      if (wait_cnt == 0) hold_addr = ram_addr;
      else if (ram_addr !== hold_addr) unstable = 1;
      if (wait_cnt >= stall) begin
        ram_ready = 1'b1;
        ram_data  = beat_of(ram_addr);
        beat_q.push_back(ram_addr);
        wait_cnt  = 0;
      end else begin
        ram_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      ram_ready = junk;
      ram_data  = junk ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0;
      wait_cnt  = 0;
    end
  end

  task automatic do_fetch(input logic [31:0] a, input int fence_cyc,
                          output logic [63:0] d, output int lat);
    int cyc;
    cyc = 0;
    lat = -1;
    d = '0;
    addr = a;
    req = 1'b1;
    fence = (fence_cyc == 0);
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      fence = (cyc == fence_cyc);
      if (if_vld) begin
        lat = cyc;
        d = if_rdata;
        break;
      end
    end
    req = 1'b0;
    fence = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; fence = 1'b0; addr = '0;
    ram_ready = 1'b0; ram_data = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (if_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b want 0", if_vld); end
    vectors++; if (if_rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", if_rdata); end
    vectors++; if (ram_vld !== 1'b0) begin miscompares++; $display("FAIL reset_ram_vld got %b want 0", ram_vld); end
    vectors++; if (ram_addr !== 32'h0) begin miscompares++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    vectors++; if (ram_mask !== 8'h0) begin miscompares++; $display("FAIL reset_ram_mask got %h want 0", ram_mask); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss;
    logic [63:0] d; int lat;
    beat_q.delete(); mask_bad = 0;
    do_fetch(32'h8000_0004, -1, d, lat);
    vectors++; if (d !== 64'h13) begin miscompares++; $display("FAIL cold_data got %h want 13", d); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL cold_lat got %0d want 5", lat); end
    vectors++; if (beat_q.size() !== 2) begin miscompares++; $display("FAIL cold_beats got %0d want 2", beat_q.size()); end
    else begin
      vectors++; if (beat_q[0] !== 32'h8000_0000) begin miscompares++; $display("FAIL cold_beat0 got %h want 80000000", beat_q[0]); end
      vectors++; if (beat_q[1] !== 32'h8000_0008) begin miscompares++; $display("FAIL cold_beat1 got %h want 80000008", beat_q[1]); end
    end
    vectors++; if (mask_bad !== 1'b0) begin miscompares++; $display("FAIL cold_mask got bad want ff"); end
    @(posedge clk); #1;
    vectors++; if (if_vld !== 1'b0 || if_rdata !== 64'h0) begin miscompares++; $display("FAIL cold_pulse got vld=%b data=%h want 0/0", if_vld, if_rdata); end
  endtask

  task automatic test_hit;
    logic [63:0] d; int lat; int rc;
    rc = req_cyc;
    do_fetch(32'h8000_0000, -1, d, lat);
    vectors++; if (d !== 64'h1111_1111) begin miscompares++; $display("FAIL hit0_data got %h want 11111111", d); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL hit0_lat got %0d want 1", lat); end
    do_fetch(32'h8000_000C, -1, d, lat);
    vectors++; if (d !== 64'h8000_000C) begin miscompares++; $display("FAIL hitc_data got %h want 8000000c", d); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL hitc_lat got %0d want 1", lat); end
    vectors++; if (req_cyc !== rc) begin miscompares++; $display("FAIL hit_memreq got %0d want %0d", req_cyc, rc); end
  endtask

  task automatic test_lru;
    logic [63:0] d; int lat;
    do_fetch(32'h8000_0200, -1, d, lat);
    vectors++; if (lat !== 5 || d !== 64'h8000_0200) begin miscompares++; $display("FAIL lru_fill200 got lat=%0d data=%h want 5/80000200", lat, d); end
    do_fetch(32'h8000_0000, -1, d, lat);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL lru_hit0 got %0d want 1", lat); end
    do_fetch(32'h8000_0400, -1, d, lat);
    vectors++; if (lat !== 5 || d !== 64'h8000_0400) begin miscompares++; $display("FAIL lru_fill400 got lat=%0d data=%h want 5/80000400", lat, d); end
    do_fetch(32'h8000_0000, -1, d, lat);
    vectors++; if (lat !== 1 || d !== 64'h1111_1111) begin miscompares++; $display("FAIL lru_rehit0 got lat=%0d data=%h want 1/11111111", lat, d); end
    do_fetch(32'h8000_0200, -1, d, lat);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL lru_evicted200 got %0d want 5", lat); end
  endtask

  task automatic test_fence;
    logic [63:0] d; int lat;
    do_fetch(32'h8000_0000, 0, d, lat);
    vectors++; if (lat !== 6 || d !== 64'h1111_1111) begin miscompares++; $display("FAIL fence_idle got lat=%0d data=%h want 6/11111111", lat, d); end
    do_fetch(32'h8000_0010, 1, d, lat);
    vectors++; if (lat !== 10 || d !== 64'h8000_0010) begin miscompares++; $display("FAIL fence_miss got lat=%0d data=%h want 10/80000010", lat, d); end
    do_fetch(32'h8000_0000, -1, d, lat);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL fence_flushed0 got %0d want 5", lat); end
  endtask

  task automatic test_reset_mid_refill;
    logic [63:0] d; int lat;
    addr = 32'h8000_0020; req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ram_vld !== 1'b1 || ram_addr !== 32'h8000_0028) begin miscompares++; $display("FAIL rstmid_beat1 got vld=%b addr=%h want 1/80000028", ram_vld, ram_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (ram_vld !== 1'b0 || ram_addr !== 32'h0 || ram_mask !== 8'h0) begin miscompares++; $display("FAIL rstmid_drop got vld=%b addr=%h mask=%h want 0/0/0", ram_vld, ram_addr, ram_mask); end
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_fetch(32'h8000_0000, -1, d, lat);
    vectors++; if (lat !== 5 || d !== 64'h1111_1111) begin miscompares++; $display("FAIL rstmid_refetch got lat=%0d data=%h want 5/11111111", lat, d); end
  endtask

  task automatic test_stall;
    logic [63:0] d; int lat; int pc;
    stall = 10; unstable = 0; pc = pulse_cnt;
    do_fetch(32'h8000_0030, -1, d, lat);
    repeat (3) @(posedge clk);
    #2;
    stall = 0;
    vectors++; if (lat !== 25 || d !== 64'h8000_0030) begin miscompares++; $display("FAIL stall_lat got lat=%0d data=%h want 25/80000030", lat, d); end
    vectors++; if (unstable !== 1'b0) begin miscompares++; $display("FAIL stall_addr got unstable want stable"); end
    vectors++; if (pulse_cnt - pc !== 1) begin miscompares++; $display("FAIL stall_pulses got %0d want 1", pulse_cnt - pc); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d; int lat; int rc;
    junk = 1; rc = req_cyc;
    @(posedge clk); #1;
    do_fetch(32'h8000_0030, -1, d, lat);
    vectors++; if (lat !== 1 || d !== 64'h8000_0030) begin miscompares++; $display("FAIL b2b_0 got lat=%0d data=%h want 1/80000030", lat, d); end
    do_fetch(32'h8000_0034, -1, d, lat);
    vectors++; if (lat !== 1 || d !== 64'h8000_0034) begin miscompares++; $display("FAIL b2b_1 got lat=%0d data=%h want 1/80000034", lat, d); end
    do_fetch(32'h8000_0038, -1, d, lat);
    vectors++; if (lat !== 1 || d !== 64'h8000_003C - 32'd4) begin miscompares++; $display("FAIL b2b_2 got lat=%0d data=%h want 1/80000038", lat, d); end
    vectors++; if (req_cyc !== rc) begin miscompares++; $display("FAIL b2b_memreq got %0d want %0d", req_cyc, rc); end
    junk = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_lru();
    test_fence();
    test_reset_mid_refill();
    test_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
